elastic_pipe_reg: RTL and testbench

//  Parametrised elastic pipeline register: a chain of DEPTH enabled, resettable data stages with

---
 rtl/elastic_pipe_reg.sv | 118 +++++++++++
 tb/tb_elastic_pipe_reg.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: DEPTH valid/ready stages with bubble collapsing
// and synchronous flush. Define ELASTIC_PIPE_COUNT_EN to add the registered
// occupancy port 'count'.
module elastic_pipe_reg #(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef ELASTIC_PIPE_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_nxt;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_vld;
  logic [WIDTH-1:0] dat     [DEPTH];
  logic [WIDTH-1:0] dat_nxt [DEPTH];
  logic [WIDTH-1:0] up_dat  [DEPTH];

  // Ready chain: a stage can load if it, or any stage downstream of it, has
  // room, or the consumer is taking the head item this cycle.
  always_comb begin : ready_chain
    logic room;
    room = out_ready;
    rdy  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      room   = room | ~vld[i];
      rdy[i] = room;
    end
  end

  // Flush blocks new input so nothing is accepted in the cycle it is cleared.
  assign in_ready = rdy[0] & ~flush;

  // Upstream source of each stage: the input port for stage 0, else the previous stage.
  always_comb begin
    up_vld    = '0;
    up_vld[0] = in_valid;
    up_dat[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_vld[i] = vld[i-1];
      up_dat[i] = dat[i-1];
    end
  end

  // Next-state: flush dominates; otherwise ready stages take upstream, data
  // only moves with a valid so empty stages keep their last value.
  always_comb begin
    vld_nxt = vld;
    dat_nxt = dat;
    if (flush) begin
      vld_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_nxt[i] = RST_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          vld_nxt[i] = up_vld[i];
          if (up_vld[i]) begin
            dat_nxt[i] = up_dat[i];
          end
        end
      end
    end
  end

  // Stage registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat[i] <= RST_VAL;
      end
    end else begin
      vld <= vld_nxt;
      dat <= dat_nxt;
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

`ifdef ELASTIC_PIPE_COUNT_EN
  localparam int unsigned CW = $clog2(DEPTH + 1);

  function automatic logic [CW-1:0] popcnt(input logic [DEPTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // Occupancy register tracks the stage valids as they will be after each edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= popcnt(vld_nxt);
    end
  end
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: directed DEPTH=2 scenarios plus randomized
// ordering runs on DEPTH=1 and DEPTH=4 instances, all queue-scoreboarded.
module tb_elastic_pipe_reg;

  logic clk;
  logic reset;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [31:0] c_in_data, c_out_data;
`ifdef ELASTIC_PIPE_COUNT_EN
  logic [1:0] a_count;
  logic [0:0] b_count;
  logic [2:0] c_count;
`endif

  int n_pass = 0;
  int n_tot  = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qc[$];

  elastic_pipe_reg #(.WIDTH(32), .DEPTH(2), .RST_VAL(32'h0)) u_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
`ifdef ELASTIC_PIPE_COUNT_EN
    , .count(a_count)
`endif
  );

  elastic_pipe_reg #(.WIDTH(32), .DEPTH(1), .RST_VAL(32'h0)) u_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
`ifdef ELASTIC_PIPE_COUNT_EN
    , .count(b_count)
`endif
  );

  elastic_pipe_reg #(.WIDTH(32), .DEPTH(4), .RST_VAL(32'h0)) u_c (
    .clk(clk), .reset(reset), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data)
`ifdef ELASTIC_PIPE_COUNT_EN
    , .count(c_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One cycle on the DEPTH=2 instance: drive at negedge, settle, score fires.
  task automatic a_cycle(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    a_in_valid  = v;
    a_in_data   = d;
    a_out_ready = ordy;
    a_flush     = fl;
    #1;
    if (a_out_valid && a_out_ready) begin
      chk("a_out_expected", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) chk("a_out_data", a_out_data, qa.pop_front());
    end
    if (a_in_valid && a_in_ready) qa.push_back(d);
    if (fl) qa.delete();
  endtask

  initial begin
    int b_sent;
    int c_sent;
    int cyc;

    reset = 1'b0;
    {a_flush, a_in_valid, a_out_ready} = '0; a_in_data = '0;
    {b_flush, b_in_valid, b_out_ready} = '0; b_in_data = '0;
    {c_flush, c_in_valid, c_out_ready} = '0; c_in_data = '0;

    // 1: reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data", a_out_data, 32'h0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
`ifdef ELASTIC_PIPE_COUNT_EN
    chk("rst_count", 32'(a_count), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    a_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("idle_out_valid", 32'(a_out_valid), 32'd0);
    chk("idle_in_ready", 32'(a_in_ready), 32'd1);

    // 2: back-to-back streaming, two-cycle latency
    a_cycle(1'b1, 32'h11, 1'b1, 1'b0);
    chk("s_in_ready0", 32'(a_in_ready), 32'd1);
    chk("s_out_valid0", 32'(a_out_valid), 32'd0);
    a_cycle(1'b1, 32'h22, 1'b1, 1'b0);
    chk("s_in_ready1", 32'(a_in_ready), 32'd1);
    chk("s_out_valid1", 32'(a_out_valid), 32'd0);
    a_cycle(1'b1, 32'h33, 1'b1, 1'b0);
    chk("s_in_ready2", 32'(a_in_ready), 32'd1);
    chk("s_out_valid2", 32'(a_out_valid), 32'd1);
    chk("s_out_first", a_out_data, 32'h11);
    a_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("s_out_valid3", 32'(a_out_valid), 32'd1);
    a_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("s_out_valid4", 32'(a_out_valid), 32'd1);
    a_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("s_empty_valid", 32'(a_out_valid), 32'd0);
    chk("s_empty_hold", a_out_data, 32'h33);

    // 3: back-pressure fills both stages then drains in order
    a_cycle(1'b1, 32'hA, 1'b0, 1'b0);
    chk("bp_rdy_a", 32'(a_in_ready), 32'd1);
    a_cycle(1'b1, 32'hB, 1'b0, 1'b0);
    chk("bp_rdy_b", 32'(a_in_ready), 32'd1);
    a_cycle(1'b1, 32'hC, 1'b0, 1'b0);
    chk("bp_full_rdy", 32'(a_in_ready), 32'd0);
    chk("bp_head", a_out_data, 32'hA);
`ifdef ELASTIC_PIPE_COUNT_EN
    chk("bp_count", 32'(a_count), 32'd2);
`endif
    a_cycle(1'b1, 32'hC, 1'b0, 1'b0);
    chk("bp_stable_data", a_out_data, 32'hA);
    chk("bp_stable_valid", 32'(a_out_valid), 32'd1);
    a_cycle(1'b1, 32'hC, 1'b1, 1'b0);
    chk("bp_full_pass_rdy", 32'(a_in_ready), 32'd1);
    a_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    a_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    a_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_drained", 32'(a_out_valid), 32'd0);
    chk("bp_queue_empty", 32'(qa.size()), 32'd0);

    // 4: flush of a full pipe discards contents and blocks the new item
    a_cycle(1'b1, 32'h5, 1'b0, 1'b0);
    a_cycle(1'b1, 32'h6, 1'b0, 1'b0);
    a_cycle(1'b1, 32'h7, 1'b0, 1'b1);
    chk("fl_in_ready", 32'(a_in_ready), 32'd0);
    a_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fl_out_valid", 32'(a_out_valid), 32'd0);
    chk("fl_out_data", a_out_data, 32'h0);
`ifdef ELASTIC_PIPE_COUNT_EN
    chk("fl_count", 32'(a_count), 32'd0);
`endif
    a_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fl_no_seven", 32'(a_out_valid), 32'd0);

    // 5: asynchronous reset mid-stream, checked before any clock edge
    a_cycle(1'b1, 32'h1, 1'b0, 1'b0);
    a_cycle(1'b1, 32'h2, 1'b0, 1'b0);
    a_cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("ar_before", 32'(a_out_valid), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("ar_out_valid", 32'(a_out_valid), 32'd0);
    chk("ar_out_data", a_out_data, 32'h0);
`ifdef ELASTIC_PIPE_COUNT_EN
    chk("ar_count", 32'(a_count), 32'd0);
`endif
    qa.delete();
    @(negedge clk);
    reset = 1'b1;
    a_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("ar_after", 32'(a_out_valid), 32'd0);

    // 6: randomized valid/ready on DEPTH=1 and DEPTH=4
    b_sent = 0;
    c_sent = 0;
    cyc    = 0;
    while ((b_sent < 1000 || c_sent < 1000 || qb.size() != 0 || qc.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      b_in_valid  = (b_sent < 1000) && ($urandom_range(0, 3) != 0);
      b_in_data   = $urandom;
      b_out_ready = (b_sent >= 1000) || ($urandom_range(0, 3) != 0);
      c_in_valid  = (c_sent < 1000) && ($urandom_range(0, 3) != 0);
      c_in_data   = $urandom;
      c_out_ready = (c_sent >= 1000) || ($urandom_range(0, 2) == 0);
      #1;
      if (b_out_valid && b_out_ready) begin
        chk("b_out_expected", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) chk("b_order", b_out_data, qb.pop_front());
      end
      if (b_in_valid && b_in_ready) begin
        qb.push_back(b_in_data);
        b_sent++;
      end
      if (c_out_valid && c_out_ready) begin
        chk("c_out_expected", 32'(qc.size() != 0), 32'd1);
        if (qc.size() != 0) chk("c_order", c_out_data, qc.pop_front());
      end
      if (c_in_valid && c_in_ready) begin
        qc.push_back(c_in_data);
        c_sent++;
      end
    end
    chk("b_sent", 32'(b_sent), 32'd1000);
    chk("b_drained", 32'(qb.size()), 32'd0);
    chk("c_sent", 32'(c_sent), 32'd1000);
    chk("c_drained", 32'(qc.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
